// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types and constants for the RV64 memory arbiter.
//   arb_state_e  - arbiter sequencing states
//   owner_e      - which requester owns the in-flight memory access
//   starve_cnt_t - width of the IF starvation counter (STARVE_MAX up to 15)
package rv_mem_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;
    localparam int unsigned STRB_W       = XLEN_DEFAULT / 8;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    typedef logic [CNT_W-1:0] starve_cnt_t;

endpackage

// File: rtl/rv_mem_arbiter_if.sv
// rv_mem_arbiter_if: bundles the IF port, the DM port and the main-memory port.
//   slave  - arbiter view: takes core requests and memory responses, drives
//            done/rdata back to the core and the mem_* request to memory.
//   master - environment view (core + memory model), the mirror image.
interface rv_mem_arbiter_if #(
    parameter int unsigned XLEN = rv_mem_pkg::XLEN_DEFAULT
);

    // Instruction fetch port (read only)
    logic              if_req;
    logic [XLEN-1:0]   if_addr;
    logic              if_done;
    logic [XLEN-1:0]   if_rdata;

    // Data memory port (load/store)
    logic              dm_req;
    logic              dm_we;
    logic [XLEN-1:0]   dm_addr;
    logic [XLEN-1:0]   dm_wdata;
    logic [XLEN/8-1:0] dm_wstrb;
    logic              dm_done;
    logic [XLEN-1:0]   dm_rdata;

    // Main memory port
    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_done, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_done, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_done, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_done, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/rv_mem_arb_pick.sv
// rv_mem_arb_pick: combinational grant decision.
//   if_req_i, dm_req_i  - pending requests
//   starve_cnt_i        - consecutive DM grants made while IF was waiting
//   grant_valid_o       - some requester can be granted
//   grant_owner_o       - DM wins ties unless IF has waited STARVE_MAX grants
module rv_mem_arb_pick
    import rv_mem_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        if_req_i,
    input  logic        dm_req_i,
    input  starve_cnt_t starve_cnt_i,
    output logic        grant_valid_o,
    output owner_e      grant_owner_o
);

    localparam starve_cnt_t StarveMax = starve_cnt_t'(STARVE_MAX);

    logic if_starved;

    always_comb begin
        if_starved    = if_req_i && (starve_cnt_i == StarveMax);
        grant_valid_o = if_req_i | dm_req_i;
        grant_owner_o = OWN_IF;
        if (dm_req_i && !if_starved) begin
            grant_owner_o = OWN_DM;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: serialises IF and DM accesses onto the single-port memory.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - rv_mem_arbiter_if.slave (IF port, DM port, memory port)
// Each access walks IDLE -> BUSY -> RESP; request fields are latched at the
// grant so the mem_* outputs stay stable for the whole BUSY phase. All outputs
// are registered.
module rv_mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_DEFAULT,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rv_mem_arbiter_if.slave   bus
);

    localparam int unsigned StrbW     = XLEN / 8;
    localparam starve_cnt_t StarveMax = starve_cnt_t'(STARVE_MAX);

    arb_state_e        state_q;
    owner_e            owner_q;
    starve_cnt_t       starve_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q;
    logic [XLEN-1:0]   mem_wdata_q;
    logic [StrbW-1:0]  mem_wstrb_q;
    logic              if_done_q;
    logic              dm_done_q;
    logic [XLEN-1:0]   if_rdata_q;
    logic [XLEN-1:0]   dm_rdata_q;

    logic              grant_valid;
    owner_e            grant_owner;

    rv_mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .if_req_i      (bus.if_req),
        .dm_req_i      (bus.dm_req),
        .starve_cnt_i  (starve_q),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // With if_req high a grant is always made, so the counter
                    // only grows on DM grants that bypass a waiting IF.
                    if (!bus.if_req || (grant_owner == OWN_IF)) begin
                        starve_q <= '0;
                    end else if (starve_q != StarveMax) begin
                        starve_q <= starve_q + 4'd1;
                    end

                    if (grant_valid) begin
                        owner_q   <= grant_owner;
                        mem_req_q <= 1'b1;
                        state_q   <= BUSY;
                        if (grant_owner == OWN_DM) begin
                            mem_we_q    <= bus.dm_we;
                            mem_addr_q  <= bus.dm_addr;
                            mem_wdata_q <= bus.dm_wdata;
                            mem_wstrb_q <= bus.dm_we ? bus.dm_wstrb : '0;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.if_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '0;
                        end
                    end
                end

                BUSY: begin
                    if (bus.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= '0;
                        state_q     <= RESP;
                        if (owner_q == OWN_IF) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_done_q  <= 1'b1;
                        end else begin
                            // Stores keep the previous load data visible.
                            if (!mem_we_q) begin
                                dm_rdata_q <= bus.mem_rdata;
                            end
                            dm_done_q <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    // No grant here: a held req must be re-sampled in IDLE.
                    if_done_q <= 1'b0;
                    dm_done_q <= 1'b0;
                    state_q   <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Arbitrates the single-port unified main memory between two requesters of the RV64 core: the instruction-fetch (IF) port and the data-memory (DM) load/store port.
- Sits between the core and the main memory model.
- Serialises accesses with a small FSM, applies fixed DM-over-IF priority with a starvation guard, and returns registered read data with a one-cycle done pulse per requester.

Parameters:
- XLEN, 64, data and address width.
- STARVE_MAX, 4, consecutive DM grants allowed while IF is waiting before IF is forced a grant (range 1..15).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF access request; held high until if_done.
- if_addr  in  XLEN  IF byte address; read only.
- if_done  out  1  one-cycle pulse; if_rdata valid in the same cycle.
- if_rdata  out  XLEN  IF read data, registered.
- dm_req  in  1  DM access request; held high until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  XLEN  DM byte address.
- dm_wdata  in  XLEN  store data.
- dm_wstrb  in  XLEN/8  byte write strobes.
- dm_done  out  1  one-cycle pulse; dm_rdata valid in the same cycle (loads only).
- dm_rdata  out  XLEN  DM read data, registered.
- mem_req  out  1  memory request, registered; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_wstrb  out  XLEN/8  memory strobes; all zero on reads.
- mem_ack  in  1  memory completion; variable latency of at least 1 cycle after mem_req rises.
- mem_rdata  in  XLEN  memory read data, valid with mem_ack.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; starve_cnt = 0; owner = IF.
  - All outputs 0, including rdata registers.
  - Reset mid-transaction abandons the access; no done pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch owner and the selected request fields (addr, we, wdata, wstrb) into mem_* registers; set mem_req = 1 at the next edge; go to BUSY.
  - IF reads force mem_we = 0 and mem_wstrb = 0.
- Grant selection:
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both: grant DM, unless starve_cnt == STARVE_MAX, in which case grant IF.
- Starvation counter:
  - DM grant while if_req is high: starve_cnt += 1, saturating at STARVE_MAX.
  - Any IF grant, or IDLE with if_req low: starve_cnt = 0.
- BUSY:
  - mem_* outputs held stable.
  - On mem_ack: capture mem_rdata into the owner's rdata register (DM stores leave dm_rdata unchanged); clear mem_req; go to RESP.
- RESP:
  - Owner's done = 1 for exactly this cycle; return to IDLE.
  - No grant is made in RESP, so a requester's held req is not re-granted.
  - The requester drops req or presents its next request at the edge ending RESP.
- Latency: request sampled in IDLE at cycle N; mem_req high from N+1; mem_ack at cycle M ≥ N+1; done at M+1; next grant decided at M+2. Minimum 3 cycles per access.
- Protocol violations:
  - Requester drops req while its access is in BUSY: the access still completes and done still pulses.
  - mem_ack outside BUSY is ignored.
  - Request fields changing during BUSY have no effect, because the fields were latched in IDLE.
- Outputs are never X after reset: rdata registers reset to 0 and hold their last value between accesses.

Decomposition:
- rv_mem_pkg holds:
  - arb_state_e enum {IDLE, BUSY, RESP}.
  - owner_e enum {OWN_IF, OWN_DM}.
  - Constant STRB_W = XLEN/8.
- One natural sub-module: rv_mem_arb_pick.
  - Combinational priority and starvation decision.
  - Inputs: if_req, dm_req, starve_cnt.
  - Outputs: grant_valid, grant_owner.
  - Keeps the FSM file focused on sequencing.

Test Plan:
1. Lone IF read:
   - Stimulus: if_addr = 0x100; memory acks 2 cycles after mem_req with rdata 0x0000_0000_0010_0093.
   - Required: mem_req high for 2 cycles with mem_we = 0 and mem_wstrb = 0; if_done pulses once with that rdata; dm_done stays 0.
2. Simultaneous requests:
   - Stimulus: if_req and dm_req both raised in the same cycle; DM store of 0xDEAD_BEEF_0000_0001 to 0x1000_0000, wstrb = 0xFF.
   - Required: DM is served first (mem_we = 1, data and strobes match); IF is granted in the IDLE cycle after the DM RESP.
3. Starvation guard:
   - Stimulus: STARVE_MAX = 4; dm_req held continuously with back-to-back stores; if_req held high.
   - Required: IF is granted on the 5th arbitration; afterwards starve_cnt = 0.
4. Zero-wait memory:
   - Stimulus: mem_ack asserted in the first cycle mem_req is high, over 10 DM loads.
   - Required: exactly one access every 3 cycles; each dm_rdata matches its mem_rdata.
5. Reset mid-BUSY:
   - Stimulus: assert rst_n = 0 asynchronously between clock edges while mem_req = 1.
   - Required: all outputs 0 immediately; no done pulse; after release, a fresh IF request at 0x0 completes normally.
6. Request drop and stray ack:
   - Stimulus: dm_req deasserted during BUSY; later, mem_ack pulsed during IDLE.
   - Required: dm_done still pulses for the in-flight access; the stray ack causes no state change and no done.
